multicycle_controller: RTL

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/ctrl_pkg.sv | 115 +++++++++++
 rtl/cond_unit.sv | 48 ++++
 rtl/multicycle_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Purpose  : Shared state enum, control codes and condition evaluation for
//            the multicycle controller.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] c_alu_add = 2'b00;
    localparam logic [1:0] c_alu_sub = 2'b01;
    localparam logic [1:0] c_alu_and = 2'b10;
    localparam logic [1:0] c_alu_orr = 2'b11;

    localparam logic [1:0] c_srcb_reg  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_data   = 2'b01;
    localparam logic [1:0] c_res_alures = 2'b10;

    localparam logic [1:0] c_imm_dp  = 2'b00;
    localparam logic [1:0] c_imm_mem = 2'b01;
    localparam logic [1:0] c_imm_br  = 2'b10;

    localparam logic [1:0] c_op_dp  = 2'b00;
    localparam logic [1:0] c_op_mem = 2'b01;
    localparam logic [1:0] c_op_br  = 2'b10;

    localparam logic [3:0] c_cmd_and = 4'b0000;
    localparam logic [3:0] c_cmd_sub = 4'b0010;
    localparam logic [3:0] c_cmd_add = 4'b0100;
    localparam logic [3:0] c_cmd_cmp = 4'b1010;
    localparam logic [3:0] c_cmd_orr = 4'b1100;

    localparam logic [3:0] c_cond_eq = 4'b0000;
    localparam logic [3:0] c_cond_ne = 4'b0001;
    localparam logic [3:0] c_cond_cs = 4'b0010;
    localparam logic [3:0] c_cond_cc = 4'b0011;
    localparam logic [3:0] c_cond_mi = 4'b0100;
    localparam logic [3:0] c_cond_pl = 4'b0101;
    localparam logic [3:0] c_cond_vs = 4'b0110;
    localparam logic [3:0] c_cond_vc = 4'b0111;
    localparam logic [3:0] c_cond_hi = 4'b1000;
    localparam logic [3:0] c_cond_ls = 4'b1001;
    localparam logic [3:0] c_cond_ge = 4'b1010;
    localparam logic [3:0] c_cond_lt = 4'b1011;
    localparam logic [3:0] c_cond_gt = 4'b1100;
    localparam logic [3:0] c_cond_le = 4'b1101;
    localparam logic [3:0] c_cond_al = 4'b1110;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic [1:0] resultsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] alucontrol;
    } ctrl_t;

    localparam ctrl_t c_ctrl_fetch = '{pcwrite: 1'b1, adrsrc: 1'b0, memwrite: 1'b0,
                                       irwrite: 1'b1, regwrite: 1'b0,
                                       resultsrc: c_res_alures, alusrca: 1'b1,
                                       alusrcb: c_srcb_four, alucontrol: c_alu_add};

    localparam ctrl_t c_ctrl_decode = '{pcwrite: 1'b0, adrsrc: 1'b0, memwrite: 1'b0,
                                        irwrite: 1'b0, regwrite: 1'b0,
                                        resultsrc: c_res_alures, alusrca: 1'b1,
                                        alusrcb: c_srcb_four, alucontrol: c_alu_add};

    // flags are packed {N,Z,C,V}
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = flags;
        case (cond)
            c_cond_eq: r = z;
            c_cond_ne: r = ~z;
            c_cond_cs: r = c;
            c_cond_cc: r = ~c;
            c_cond_mi: r = n;
            c_cond_pl: r = ~n;
            c_cond_vs: r = v;
            c_cond_vc: r = ~v;
            c_cond_hi: r = c & ~z;
            c_cond_ls: r = ~c | z;
            c_cond_ge: r = (n == v);
            c_cond_lt: r = (n != v);
            c_cond_gt: r = ~z & (n == v);
            c_cond_le: r = z | (n != v);
            c_cond_al: r = 1'b1;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_unit
// Purpose  : Condition evaluation, per-instruction CondEx latch and NZCV
//            flag register.
// Revision : 1.0 - initial release
// ============================================================================
module cond_unit
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_aluflags,
    input  logic       i_latch,
    input  logic       i_upd_nz,
    input  logic       i_upd_cv,
    output logic       o_condex_eval,
    output logic       o_condex
);

    logic [3:0] r_flags;
    logic       r_condex;
    logic       w_condex_eval;

    assign w_condex_eval = cond_eval(i_cond, r_flags);
    assign o_condex_eval = w_condex_eval;
    assign o_condex      = r_condex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags  <= 4'b0000;
            r_condex <= 1'b0;
        end else begin
            if (i_latch) begin
                r_condex <= w_condex_eval;
            end
            if (i_upd_nz) begin
                r_flags[3:2] <= i_aluflags[3:2];
            end
            if (i_upd_cv) begin
                r_flags[1:0] <= i_aluflags[1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Purpose  : Moore control FSM for a multicycle ARM-subset datapath.
//            Optional feature: define MEM_WAIT_EN to add MemReady handshaking.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
`ifdef MEM_WAIT_EN
    input  logic       MemReady,
`endif
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl
);

    state_t     r_state;
    state_t     w_state_next;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl_next;

    logic       w_mem_ready;
    logic       w_condex_eval;
    logic       w_condex;
    logic       w_condex_next;
    logic [1:0] w_dp_alu;
    logic       w_nowrite;
    logic       w_dp_known;
    logic       w_dp_arith;
    logic       w_flag_en;
    logic       w_rd15;
    logic       w_aluwb_reg;

`ifdef MEM_WAIT_EN
    assign w_mem_ready = MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    assign w_rd15 = (Rd == 4'd15);

    always_comb begin
        w_dp_alu   = c_alu_add;
        w_nowrite  = 1'b1;
        w_dp_known = 1'b0;
        w_dp_arith = 1'b0;
        case (Funct[4:1])
            c_cmd_add: begin w_dp_alu = c_alu_add; w_nowrite = 1'b0; w_dp_known = 1'b1; w_dp_arith = 1'b1; end
            c_cmd_sub: begin w_dp_alu = c_alu_sub; w_nowrite = 1'b0; w_dp_known = 1'b1; w_dp_arith = 1'b1; end
            c_cmd_and: begin w_dp_alu = c_alu_and; w_nowrite = 1'b0; w_dp_known = 1'b1; end
            c_cmd_orr: begin w_dp_alu = c_alu_orr; w_nowrite = 1'b0; w_dp_known = 1'b1; end
            c_cmd_cmp: begin w_dp_alu = c_alu_sub; w_dp_known = 1'b1; w_dp_arith = 1'b1; end
            default:   ;
        endcase
    end

    // Logical ops leave C and V untouched; unknown commands touch nothing.
    assign w_flag_en = ((r_state == EXECUTER) || (r_state == EXECUTEI))
                       & Funct[0] & w_condex & w_dp_known;

    cond_unit u_cond (
        .clk           (CLK),
        .rst_n         (reset),
        .i_cond        (Cond),
        .i_aluflags    (ALUFlags),
        .i_latch       (r_state == DECODE),
        .i_upd_nz      (w_flag_en),
        .i_upd_cv      (w_flag_en & w_dp_arith),
        .o_condex_eval (w_condex_eval),
        .o_condex      (w_condex)
    );

    // Outputs are registered from the next state, so the CondEx that will
    // be latched on the DECODE exit edge is needed one edge early.
    assign w_condex_next = (r_state == DECODE) ? w_condex_eval : w_condex;
    assign w_aluwb_reg   = w_condex_next & ~w_nowrite;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:    if (w_mem_ready) w_state_next = DECODE;
            DECODE: begin
                case (Op)
                    c_op_dp:  w_state_next = Funct[5] ? EXECUTEI : EXECUTER;
                    c_op_mem: w_state_next = MEMADR;
                    c_op_br:  w_state_next = BRANCH;
                    default:  w_state_next = FETCH;
                endcase
            end
            MEMADR:   w_state_next = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  if (w_mem_ready) w_state_next = MEMWB;
            MEMWRITE: if (w_mem_ready) w_state_next = FETCH;
            EXECUTER: w_state_next = ALUWB;
            EXECUTEI: w_state_next = ALUWB;
            default:  w_state_next = FETCH;
        endcase
    end

    always_comb begin
        w_ctrl_next = '0;
        case (w_state_next)
            FETCH:    w_ctrl_next = c_ctrl_fetch;
            DECODE:   w_ctrl_next = c_ctrl_decode;
            MEMADR: begin
                w_ctrl_next.alusrcb    = c_srcb_imm;
                w_ctrl_next.alucontrol = Funct[3] ? c_alu_add : c_alu_sub;
            end
            MEMREAD:  w_ctrl_next.adrsrc = 1'b1;
            MEMWRITE: begin
                w_ctrl_next.adrsrc   = 1'b1;
                w_ctrl_next.memwrite = w_condex_next;
            end
            MEMWB: begin
                w_ctrl_next.resultsrc = c_res_data;
                w_ctrl_next.regwrite  = w_condex_next;
                w_ctrl_next.pcwrite   = w_condex_next & w_rd15;
            end
            EXECUTER: begin
                w_ctrl_next.alusrcb    = c_srcb_reg;
                w_ctrl_next.alucontrol = w_dp_alu;
            end
            EXECUTEI: begin
                w_ctrl_next.alusrcb    = c_srcb_imm;
                w_ctrl_next.alucontrol = w_dp_alu;
            end
            ALUWB: begin
                w_ctrl_next.resultsrc = c_res_aluout;
                w_ctrl_next.regwrite  = w_aluwb_reg;
                w_ctrl_next.pcwrite   = w_aluwb_reg & w_rd15;
            end
            BRANCH: begin
                w_ctrl_next.alusrcb   = c_srcb_imm;
                w_ctrl_next.resultsrc = c_res_alures;
                w_ctrl_next.pcwrite   = w_condex_next;
            end
            default:  w_ctrl_next = c_ctrl_fetch;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
            r_ctrl  <= c_ctrl_fetch;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= w_ctrl_next;
        end
    end

    // Write enables are gated by the live reset level and by the memory
    // handshake in the states that wait on it.
    assign PCWrite    = reset & r_ctrl.pcwrite & ((r_state != FETCH) | w_mem_ready);
    assign IRWrite    = reset & r_ctrl.irwrite & w_mem_ready;
    assign MemWrite   = reset & r_ctrl.memwrite & w_mem_ready;
    assign RegWrite   = reset & r_ctrl.regwrite;
    assign AdrSrc     = r_ctrl.adrsrc;
    assign ResultSrc  = r_ctrl.resultsrc;
    assign ALUSrcA    = r_ctrl.alusrca;
    assign ALUSrcB    = r_ctrl.alusrcb;
    assign ALUControl = r_ctrl.alucontrol;
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == c_op_mem, Op == c_op_br};

endmodule
`default_nettype wire
